floo_vc_credit_sched: RTL
=========================

Name: floo_vc_credit_sched

Overview:
- Output-port scheduler that shares one physical link among NumVirtChannels virtual channels using credit-based flow control.
- Keeps one credit counter per VC that mirrors free buffer slots in the downstream router.
- Picks one eligible VC per cycle using round-robin order.
- Holds the grant on a VC until the last flit of a packet, so wormhole packets are never interleaved.
- Sits between the per-VC output buffers and the physical link. It replaces the valid/ready scheme toward the next router with valid plus credit return.

Parameters:
- NumVirtChannels, 2, number of VCs sharing the link; must be >= 1.
- NumCredits, 4, downstream buffer depth per VC; reset value of each credit counter; must be >= 1.
- flit_t, logic, flit payload type.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  NumVirtChannels  per-VC flit valid from the VC buffers.
- ready_o  output  NumVirtChannels  per-VC pop; one-hot or zero.
- data_i  input  NumVirtChannels x flit_t  per-VC flit.
- last_i  input  NumVirtChannels  per-VC flag: the flit is the packet tail.
- valid_o  output  1  flit sent on the physical link this cycle.
- vc_id_o  output  max(1,$clog2(NumVirtChannels))  VC of the sent flit.
- data_o  output  flit_t  sent flit.
- credit_valid_i  input  1  downstream returns one credit.
- credit_id_i  input  max(1,$clog2(NumVirtChannels))  VC that the returned credit belongs to.
- credit_zero_o  output  NumVirtChannels  per-VC flag: credit counter is 0 (for debug and perf counters).

Behaviour:
- State:
  - cnt[v], width $clog2(NumCredits+1).
  - rr_ptr, index width.
  - locked, 1 bit.
  - lock_idx, index width.
  - Reset values: cnt = NumCredits, rr_ptr = 0, locked = 0, lock_idx = 0.
- Outputs during and right after reset: valid_o = 0, ready_o = 0, credit_zero_o = 0.
- Eligibility: elig[v] = valid_i[v] && cnt[v] != 0.
- Selection is combinational, zero-cycle latency from valid_i to valid_o.
  - Unlocked: winner = first v with elig[v], scanning rr_ptr, rr_ptr+1, … mod NumVirtChannels.
  - Locked: winner = lock_idx only if elig[lock_idx]. Otherwise valid_o = 0. No other VC is granted, even if eligible.
- Send: when a winner exists:
  - valid_o = 1, vc_id_o = winner, data_o = data_i[winner], ready_o[winner] = 1.
  - The send is unconditional: the link has no back-pressure, and credits guarantee buffer space.
- Idle outputs: when valid_o = 0, ready_o = 0, and vc_id_o and data_o are don't-care (drive 0).
- Lock FSM, updated on a send:
  - UNLOCKED to LOCKED if last_i[winner] = 0; lock_idx <= winner.
  - LOCKED to UNLOCKED when a send has last_i = 1.
  - Any send with last_i = 1: rr_ptr <= (winner+1) mod NumVirtChannels. A single-flit packet never enters LOCKED.
  - rr_ptr does not change on non-tail flits or on idle cycles.
- Credits, per cycle:
  - A send on v decrements cnt[v].
  - credit_valid_i with credit_id_i = v increments cnt[v].
  - Both on the same v in the same cycle: cnt[v] stays the same.
  - Both on different VCs: each counter updates independently.
- Overflow: a credit return to a counter already at NumCredits with no simultaneous send is a protocol error. The counter saturates at NumCredits, and a simulation assertion fires.
- Underflow is impossible because elig requires cnt != 0.
- credit_id_i >= NumVirtChannels while credit_valid_i = 1 is ignored and trips an assertion.
- credit_zero_o[v] = (cnt[v] == 0), driven from registers.
- Credit starvation mid-packet: the link stalls on that VC until a credit returns. The lock is held throughout.
- Reset asserted mid-packet clears the lock and restores all counters and rr_ptr immediately, asynchronously.
- NumVirtChannels = 1: vc_id_o is always 0. The RR and lock logic degenerate, but the credit behaviour is unchanged.
- Assertions:
  - ready_o is one-hot or zero.
  - valid_o implies ready_o != 0.
  - cnt never exceeds NumCredits.

Test Plan:
- Reset with NumVirtChannels = 2, NumCredits = 4, both valid_i high, all last_i = 1, no credit returns -> grants alternate VC0, VC1, VC0, VC1, VC0, VC1, VC0, VC1. Then valid_o = 0 and credit_zero_o = 2'b11.
- VC0 sends a 3-flit packet (last on flit 3) while VC1 is valid throughout -> three consecutive VC0 sends, then VC1; vc_id_o sequence is 0, 0, 0, 1.
- VC0 locked after its first flit with cnt[0] = 0, VC1 eligible -> valid_o = 0 for the stall cycles. Return a credit for VC0 -> VC0 resumes the next cycle; VC1 is never granted while the lock is held.
- cnt[1] = 2, a VC1 send and credit_valid_i with id 1 in the same cycle -> cnt[1] stays 2 and credit_zero_o[1] = 0.
- Return a credit to a VC with cnt = 4 -> the assertion fires and the counter stays at 4.
- Assert rst_ni mid-packet with VC1 locked -> after release, VC0 is granted first, all counters read 4, and locked = 0.

Source files
------------

// File: rtl/floo_vc_credit_sched.sv
// Credit-based virtual-channel scheduler: shares one physical link among VCs
// with round-robin arbitration, wormhole locking and per-VC downstream credits.
module floo_vc_credit_sched #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumCredits      = 4,
  parameter type         flit_t          = logic,
  localparam int unsigned IdxW = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1,
  localparam int unsigned CntW = $clog2(NumCredits + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  flit_t [NumVirtChannels-1:0] data_i,
  input  logic [NumVirtChannels-1:0] last_i,
  output logic                       valid_o,
  output logic [IdxW-1:0]            vc_id_o,
  output flit_t                      data_o,
  input  logic                       credit_valid_i,
  input  logic [IdxW-1:0]            credit_id_i,
  output logic [NumVirtChannels-1:0] credit_zero_o
);

  typedef enum logic {StUnlocked = 1'b0, StLocked = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic                        locked;
  logic [IdxW-1:0]             rr_q, rr_d;
  logic [IdxW-1:0]             lock_idx_q, lock_idx_d;
  logic [CntW-1:0]             cnt_q [NumVirtChannels];
  logic [CntW-1:0]             cnt_d [NumVirtChannels];
  logic [NumVirtChannels-1:0]  elig;
  logic [NumVirtChannels-1:0]  zero_d;
  logic                        send;
  logic                        win_last;
  logic [IdxW-1:0]             winner;
  logic [IdxW:0]               scan;

  assign locked = (state_q == StLocked);

  // A VC may only be picked when it has a flit and downstream space.
  always_comb begin
    elig = '0;
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      elig[v] = valid_i[v] && (cnt_q[v] != '0);
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StUnlocked;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  // Lock FSM next state: a non-tail flit pins the link, a tail advances RR.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (send) begin
      if (win_last) begin
        state_d = StUnlocked;
        if (32'(winner) == NumVirtChannels - 1) rr_d = '0;
        else                                    rr_d = winner + IdxW'(1);
      end else begin
        state_d    = StLocked;
        lock_idx_d = winner;
      end
    end
  end

  // Winner selection and link outputs; zero latency from valid_i.
  always_comb begin
    send     = 1'b0;
    winner   = '0;
    scan     = '0;
    ready_o  = '0;
    valid_o  = 1'b0;
    vc_id_o  = '0;
    data_o   = '0;
    win_last = 1'b0;
    if (locked) begin
      send   = elig[lock_idx_q];
      winner = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumVirtChannels; i++) begin
        scan = {1'b0, rr_q} + (IdxW + 1)'(i);
        if (32'(scan) >= NumVirtChannels) scan = scan - (IdxW + 1)'(NumVirtChannels);
        if (!send && elig[IdxW'(scan)]) begin
          send   = 1'b1;
          winner = IdxW'(scan);
        end
      end
    end
    if (!rst_ni) send = 1'b0;
    if (send) begin
      valid_o         = 1'b1;
      vc_id_o         = winner;
      data_o          = data_i[winner];
      ready_o[winner] = 1'b1;
      win_last        = last_i[winner];
    end
  end

  // Credit counters: send consumes, return replenishes, saturating at max.
  always_comb begin
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      cnt_d[v] = cnt_q[v];
      if ((credit_valid_i && credit_id_i == IdxW'(v)) && !(send && winner == IdxW'(v))) begin
        if (cnt_q[v] != CntW'(NumCredits)) cnt_d[v] = cnt_q[v] + CntW'(1);
      end else if (!(credit_valid_i && credit_id_i == IdxW'(v)) && (send && winner == IdxW'(v))) begin
        cnt_d[v] = cnt_q[v] - CntW'(1);
      end
      zero_d[v] = (cnt_d[v] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned v = 0; v < NumVirtChannels; v++) cnt_q[v] <= CntW'(NumCredits);
      credit_zero_o <= '0;
    end else begin
      for (int unsigned v = 0; v < NumVirtChannels; v++) cnt_q[v] <= cnt_d[v];
      credit_zero_o <= zero_d;
    end
  end

`ifndef SYNTHESIS
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      if (credit_valid_i && credit_id_i == IdxW'(v) && cnt_q[v] == CntW'(NumCredits)
          && !(send && winner == IdxW'(v))) ovf = 1'b1;
    end
  end

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_o));
  a_valid_ready:  assert property (@(posedge clk_i) disable iff (!rst_ni) valid_o |-> (ready_o != '0));
  a_credit_ovf:   assert property (@(posedge clk_i) disable iff (!rst_ni) !ovf);
  a_credit_id:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   credit_valid_i |-> (32'(credit_id_i) < NumVirtChannels));
  for (genvar g = 0; g < NumVirtChannels; g++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q[g] <= CntW'(NumCredits));
  end
`endif

endmodule
